frame_buf_arb: RTL and testbench
================================

FRAME_BUF_ARB -- requirements
Module: frame_buf_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the memory data word.
REQ-002 Parameter ADDR_WIDTH, default 29, width of the memory word address.
REQ-003 Parameter BURST_LEN, default 16, beats per burst; legal range 2..256.
REQ-004 Parameter RD_TIMEOUT, default 15, maximum cycles to wait for one read beat.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 wr_req  in  1  active-high; writer requests one write burst.
REQ-008 wr_start_addr  in  ADDR_WIDTH  first word address of the write burst.
REQ-009 wr_data  in  DATA_WIDTH  current write beat from the writer.
REQ-010 wr_grant  out  1  one-cycle pulse; write burst started.
REQ-011 wr_data_ack  out  1  one-cycle pulse; current wr_data consumed, present the next beat.
REQ-012 wr_done  out  1  one-cycle pulse; last write beat accepted.
REQ-013 rd_req  in  1  active-high; reader requests one read burst.
REQ-014 rd_start_addr  in  ADDR_WIDTH  first word address of the read burst.
REQ-015 rd_grant  out  1  one-cycle pulse; read burst started.
REQ-016 rd_data  out  DATA_WIDTH  read beat to the reader.
REQ-017 rd_data_valid  out  1  one-cycle pulse per returned beat.
REQ-018 rd_done  out  1  one-cycle pulse; last read beat delivered.
REQ-019 rd_err  out  1  one-cycle pulse; read burst aborted on timeout.
REQ-020 mem_wr_en, mem_rd_en  out  1 each  active-low memory enables.
REQ-021 mem_wr_addr, mem_rd_addr  out  ADDR_WIDTH  memory addresses.
REQ-022 mem_wr_data  out  DATA_WIDTH  memory write data; equals wr_data combinationally.
REQ-023 mem_wr_rdy, mem_rd_data_valid  in  1 each  active-high memory status.
REQ-024 mem_rd_data  in  DATA_WIDTH  memory read data.

Function
REQ-025 The FSM shall have exactly the states IDLE, WR_BURST and RD_BURST.
REQ-026 In IDLE, request selection shall work as follows:
- Only one request high: that requester is granted.
- Both requests high: the requester not granted last is granted (round-robin).
- After reset, the first tie goes to read.
REQ-027 A grant shall take effect as follows:
- The grant pulse is asserted in the cycle IDLE exits.
- The start address is latched into a base register.
- The beat counter is cleared.
REQ-028 Requests shall be ignored outside IDLE, and IDLE shall last at least one cycle between bursts.
REQ-029 Write beat addressing: in WR_BURST, mem_wr_en shall be low and mem_wr_addr shall equal base+count.
REQ-030 A write beat is accepted in a cycle where mem_wr_rdy=1 while mem_wr_en=0; that cycle shall pulse wr_data_ack and increment count.
REQ-031 On acceptance of beat BURST_LEN-1, the block shall pulse wr_done, return to IDLE and drive mem_wr_en high.
REQ-032 Read beat addressing: in RD_BURST, mem_rd_en shall be low, mem_rd_addr shall equal base+count, and only one beat shall be outstanding.
REQ-033 On mem_rd_data_valid=1, the block shall do all of the following:
- Register mem_rd_data to rd_data.
- Pulse rd_data_valid one cycle later.
- Increment count, which advances the address.
REQ-034 On delivery of beat BURST_LEN-1, rd_done shall pulse coincident with the last rd_data_valid, and the FSM shall return to IDLE.
REQ-035 The timeout counter shall clear on every mem_rd_data_valid; if it reaches RD_TIMEOUT, the block shall pulse rd_err, drop mem_rd_en and go to IDLE without rd_done.
REQ-036 Address arithmetic is modulo 2^ADDR_WIDTH; the burst wraps from all-ones to 0 without error.
REQ-037 mem_wr_en and mem_rd_en shall never be low in the same cycle.

Reset
REQ-038 On reset low, asynchronously and regardless of state, the block shall:
- Set the state to IDLE.
- Drive mem_wr_en=1 and mem_rd_en=1.
- Drive all pulses to 0, rd_data=0, addresses=0.
- Clear count and the timeout counter.
- Set the round-robin pointer to favour read.
REQ-039 An in-progress burst is abandoned on reset, and no done pulse is produced.

Structure
REQ-040 The state encodings and the ASSERT_L/DEASSERT_L/ASSERT_H/DEASSERT_H constants shall reside in the shared frame_buf_pkg header.
REQ-041 Round-robin grant logic shall be one sub-module, rr_arb2, with inputs req[1:0] and last and output gnt[1:0].

Verification
REQ-042 Scenario: wr_req=1 only, start=0x100, BURST_LEN=16, mem_wr_rdy=1 -> wr_grant, then 16 writes to 0x100..0x10F, then wr_done, then IDLE.
REQ-043 Scenario: both requests at the first cycle after reset -> read granted first; a second tie -> write granted.
REQ-044 Scenario: read start=2^29-2 -> addresses 0x1FFFFFFE, 0x1FFFFFFF, 0x0..0xD; 16 rd_data_valid pulses; rd_done coincident with the 16th.
REQ-045 Scenario: mem_wr_rdy held 0 for 5 cycles mid-burst -> address and count held, no wr_data_ack, burst resumes.
REQ-046 Scenario: mem_rd_data_valid withheld after beat 3 -> rd_err after 15 cycles, no rd_done, IDLE.
REQ-047 Scenario: reset asserted at write beat 7 -> mem_wr_en=1 immediately, no wr_done; after release, the next tie grants read.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// Shared constants for the frame buffer arbiter: FSM state encodings,
// enable polarity helpers and requester indices.
package frame_buf_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_BURST = 2'd1;
  localparam logic [1:0] RD_BURST = 2'd2;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  // Requester positions in the req/gnt vectors of rr_arb2.
  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;

endpackage

// File: rtl/frame_buf_arb_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
// last = 1 means the read side (REQ_RD) was granted most recently.
module rr_arb2
  import frame_buf_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[REQ_WR] && req[REQ_RD]) begin
      if (last) gnt[REQ_WR] = ASSERT_H;
      else      gnt[REQ_RD] = ASSERT_H;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/frame_buf_arb.sv
// Frame buffer arbiter: grants one write or read burst at a time to a shared
// single-port style memory interface, with read-beat timeout.
//
// state    | meaning
// IDLE     | no burst; arbitrate wr_req/rd_req, grant and latch base address
// WR_BURST | mem_wr_en low, one beat accepted per mem_wr_rdy
// RD_BURST | mem_rd_en low, one beat outstanding, timeout armed
module frame_buf_arb
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 29,
  parameter int BURST_LEN  = 16,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_start_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_grant,
  output logic                  wr_data_ack,
  output logic                  wr_done,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_start_addr,
  output logic                  rd_grant,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_rdy,
  input  logic                  mem_rd_data_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int CW = $clog2(BURST_LEN);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         count_q, count_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_data_valid_q, rd_data_valid_d;
  logic                  rd_done_q, rd_done_d;
  logic                  rd_err_q, rd_err_d;
  logic [1:0]            gnt;
  logic                  beat_last;
  logic [ADDR_WIDTH-1:0] beat_addr;

  rr_arb2 u_rr_arb2 (
    .req  ({rd_req, wr_req}),
    .last (last_q),
    .gnt  (gnt)
  );

  assign beat_last = (count_q == CW'(BURST_LEN - 1));
  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign beat_addr = base_q + ADDR_WIDTH'(count_q);

  // Grants are gated by reset so no pulse escapes while reset is held.
  assign wr_grant    = reset & (state_q == IDLE) & gnt[REQ_WR];
  assign rd_grant    = reset & (state_q == IDLE) & gnt[REQ_RD];
  assign wr_data_ack = (state_q == WR_BURST) & mem_wr_rdy;
  assign wr_done     = wr_data_ack & beat_last;

  assign mem_wr_en   = (state_q == WR_BURST) ? ASSERT_L : DEASSERT_L;
  assign mem_rd_en   = (state_q == RD_BURST) ? ASSERT_L : DEASSERT_L;
  assign mem_wr_addr = beat_addr;
  assign mem_rd_addr = beat_addr;
  assign mem_wr_data = wr_data;

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign rd_done       = rd_done_q;
  assign rd_err        = rd_err_q;

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    count_d         = count_q;
    tmo_d           = tmo_q;
    last_d          = last_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = DEASSERT_H;
    rd_done_d       = DEASSERT_H;
    rd_err_d        = DEASSERT_H;
    case (state_q)
      IDLE: begin
        if (gnt[REQ_RD]) begin
          state_d = RD_BURST;
          base_d  = rd_start_addr;
          count_d = '0;
          tmo_d   = '0;
          last_d  = 1'b1;
        end else if (gnt[REQ_WR]) begin
          state_d = WR_BURST;
          base_d  = wr_start_addr;
          count_d = '0;
          last_d  = 1'b0;
        end
      end
      WR_BURST: begin
        if (mem_wr_rdy) begin
          count_d = count_q + CW'(1);
          if (beat_last) state_d = IDLE;
        end
      end
      RD_BURST: begin
        if (mem_rd_data_valid) begin
          rd_data_d       = mem_rd_data;
          rd_data_valid_d = ASSERT_H;
          count_d         = count_q + CW'(1);
          tmo_d           = '0;
          if (beat_last) begin
            rd_done_d = ASSERT_H;
            state_d   = IDLE;
          end
        end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
          rd_err_d = ASSERT_H;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      base_q          <= '0;
      count_q         <= '0;
      tmo_q           <= '0;
      last_q          <= 1'b0;
      rd_data_q       <= '0;
      rd_data_valid_q <= DEASSERT_H;
      rd_done_q       <= DEASSERT_H;
      rd_err_q        <= DEASSERT_H;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      count_q         <= count_d;
      tmo_q           <= tmo_d;
      last_q          <= last_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
      rd_done_q       <= rd_done_d;
      rd_err_q        <= rd_err_d;
    end
  end

endmodule

// File: tb/tb_frame_buf_arb.sv
// Bench for frame_buf_arb: arbitration table, directed corner sequences and
// randomized bursts against a transaction-level memory/arbitration model.
module tb_frame_buf_arb;

  localparam int DW  = 32;
  localparam int AW  = 29;
  localparam int BL  = 16;
  localparam int TMO = 15;

  logic          clk, reset;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_start_addr, rd_start_addr;
  logic [DW-1:0] wr_data;
  logic          wr_grant, wr_data_ack, wr_done;
  logic          rd_grant;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid, rd_done, rd_err;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_rdy, mem_rd_data_valid;
  logic [DW-1:0] mem_rd_data;

  frame_buf_arb #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BURST_LEN  (BL),
    .RD_TIMEOUT (TMO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .wr_req            (wr_req),
    .wr_start_addr     (wr_start_addr),
    .wr_data           (wr_data),
    .wr_grant          (wr_grant),
    .wr_data_ack       (wr_data_ack),
    .wr_done           (wr_done),
    .rd_req            (rd_req),
    .rd_start_addr     (rd_start_addr),
    .rd_grant          (rd_grant),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .rd_done           (rd_done),
    .rd_err            (rd_err),
    .mem_wr_en         (mem_wr_en),
    .mem_rd_en         (mem_rd_en),
    .mem_wr_addr       (mem_wr_addr),
    .mem_rd_addr       (mem_rd_addr),
    .mem_wr_data       (mem_wr_data),
    .mem_wr_rdy        (mem_wr_rdy),
    .mem_rd_data_valid (mem_rd_data_valid),
    .mem_rd_data       (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: round-robin memory, pending registered read outputs
  // and the word store behind the memory interface.
  bit            last_rd;
  bit            pend_valid, pend_last, pend_err;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] mem [logic [AW-1:0]];

  typedef struct {
    logic w;
    logic r;
    logic exp_w;
    logic exp_r;
  } arb_vec_t;
  arb_vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_idle(input logic w, input logic r, input logic [AW-1:0] wa,
                         input logic [AW-1:0] ra, input logic exp_w, input logic exp_r);
    wr_req            = w;
    rd_req            = r;
    wr_start_addr     = wa;
    rd_start_addr     = ra;
    wr_data           = $urandom;
    mem_wr_rdy        = 1'($urandom);
    mem_rd_data_valid = 1'($urandom);
    mem_rd_data       = $urandom;
    #1;
    chk("idle_rd_valid", 64'(rd_data_valid), 64'(pend_valid));
    if (pend_valid) chk("idle_rd_data", 64'(rd_data), 64'(pend_data));
    chk("idle_rd_done", 64'(rd_done), 64'(pend_last));
    chk("idle_rd_err", 64'(rd_err), 64'(pend_err));
    chk("idle_wr_en", 64'(mem_wr_en), 64'(1));
    chk("idle_rd_en", 64'(mem_rd_en), 64'(1));
    chk("idle_wr_ack", 64'(wr_data_ack), 64'(0));
    chk("idle_wr_done", 64'(wr_done), 64'(0));
    chk("wr_grant", 64'(wr_grant), 64'(exp_w));
    chk("rd_grant", 64'(rd_grant), 64'(exp_r));
    pend_valid = 0;
    pend_last  = 0;
    pend_err   = 0;
    if (exp_r) last_rd = 1;
    else if (exp_w) last_rd = 0;
    tick();
    wr_req = 0;
    rd_req = 0;
  endtask

  // rmode=0: memory always ready except a fixed stall window; rmode=1: random stalls.
  task automatic run_write(input logic [AW-1:0] start, input int stall_at, input int stall_len,
                           input int rmode, input int rst_at);
    int            i = 0;
    int            stalls = 0;
    int            fixed_stall = 0;
    bit            fin = 0;
    logic [DW-1:0] cur;
    cur = $urandom;
    for (int c = 0; c < 400 && !fin; c++) begin
      logic [AW-1:0] a;
      logic          rdy;
      a                 = start + AW'(i);
      wr_data           = cur;
      wr_req            = 1'($urandom);
      rd_req            = 1'($urandom);
      wr_start_addr     = $urandom;
      rd_start_addr     = $urandom;
      mem_rd_data_valid = 1'($urandom);
      if (i == rst_at) begin
        reset      = 0;
        mem_wr_rdy = 1;
        #1;
        chk("rst_wr_en", 64'(mem_wr_en), 64'(1));
        chk("rst_rd_en", 64'(mem_rd_en), 64'(1));
        chk("rst_wr_done", 64'(wr_done), 64'(0));
        chk("rst_wr_ack", 64'(wr_data_ack), 64'(0));
        chk("rst_grants", 64'({wr_grant, rd_grant}), 64'(0));
        chk("rst_wr_addr", 64'(mem_wr_addr), 64'(0));
        tick();
        reset   = 1;
        last_rd = 0;
        fin     = 1;
      end else begin
        if (rmode != 0) rdy = (stalls >= 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
        else            rdy = !(i == stall_at && fixed_stall < stall_len);
        mem_wr_rdy = rdy;
        #1;
        chk("wr_en", 64'(mem_wr_en), 64'(0));
        chk("wr_rd_en", 64'(mem_rd_en), 64'(1));
        chk("wr_addr", 64'(mem_wr_addr), 64'(a));
        chk("wr_data_pass", 64'(mem_wr_data), 64'(cur));
        chk("wr_ack", 64'(wr_data_ack), 64'(rdy));
        chk("wr_done", 64'(wr_done), 64'(rdy && (i == BL - 1)));
        chk("wr_grants_ignored", 64'({wr_grant, rd_grant}), 64'(0));
        chk("wr_rd_pulses", 64'({rd_data_valid, rd_done, rd_err}), 64'(0));
        if (rdy) begin
          mem[a] = cur;
          i++;
          cur    = $urandom;
          stalls = 0;
          if (i == BL) fin = 1;
        end else begin
          stalls++;
          if (i == stall_at) fixed_stall++;
        end
        tick();
      end
    end
    if (!fin) chk("wr_burst_budget", 64'(0), 64'(1));
  endtask

  // Beat abort_beat is never returned, so the burst must end on timeout.
  task automatic run_read(input logic [AW-1:0] start, input int abort_beat, input int rmode);
    int i = 0;
    int stall = 0;
    int dly;
    bit fin = 0;
    dly = (rmode != 0) ? $urandom_range(0, 3) : 0;
    for (int c = 0; c < 600 && !fin; c++) begin
      logic [AW-1:0] a;
      bit            vnow;
      a                 = start + AW'(i);
      wr_req            = 1'($urandom);
      rd_req            = 1'($urandom);
      wr_start_addr     = $urandom;
      rd_start_addr     = $urandom;
      mem_wr_rdy        = 1'($urandom);
      vnow              = (i != abort_beat) && (stall >= dly);
      mem_rd_data_valid = vnow;
      if (vnow) begin
        if (!mem.exists(a)) mem[a] = $urandom;
        mem_rd_data = mem[a];
      end else begin
        mem_rd_data = $urandom;
      end
      #1;
      chk("rd_valid", 64'(rd_data_valid), 64'(pend_valid));
      if (pend_valid) chk("rd_data", 64'(rd_data), 64'(pend_data));
      chk("rd_done", 64'(rd_done), 64'(pend_last));
      chk("rd_err_early", 64'(rd_err), 64'(0));
      chk("rd_en", 64'(mem_rd_en), 64'(0));
      chk("rd_wr_en", 64'(mem_wr_en), 64'(1));
      chk("rd_addr", 64'(mem_rd_addr), 64'(a));
      chk("rd_wr_ack", 64'(wr_data_ack), 64'(0));
      chk("rd_grants_ignored", 64'({wr_grant, rd_grant}), 64'(0));
      pend_valid = vnow;
      pend_last  = vnow && (i == BL - 1);
      if (vnow) begin
        pend_data = mem_rd_data;
        i++;
        stall = 0;
        dly   = (rmode != 0) ? $urandom_range(0, 3) : 0;
        if (i == BL) fin = 1;
      end else begin
        stall++;
        if (stall == TMO) begin
          pend_err = 1;
          fin      = 1;
        end
      end
      tick();
    end
    if (!fin) chk("rd_burst_budget", 64'(0), 64'(1));
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 2))
      0:       return AW'(32'h100 + $urandom_range(0, 31));
      1:       return AW'(32'h1FFF_FFF0 + $urandom_range(0, 15));
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    logic          w, r, ew, er;
    logic [AW-1:0] wa, ra;

    tbl[0] = '{1, 1, 0, 1};
    tbl[1] = '{1, 1, 1, 0};
    tbl[2] = '{0, 1, 0, 1};
    tbl[3] = '{1, 1, 1, 0};
    tbl[4] = '{1, 0, 1, 0};
    tbl[5] = '{1, 1, 0, 1};
    tbl[6] = '{0, 0, 0, 0};
    tbl[7] = '{1, 1, 1, 0};
    tbl[8] = '{1, 0, 1, 0};
    tbl[9] = '{0, 1, 0, 1};

    reset             = 0;
    wr_req            = 1;
    rd_req            = 1;
    wr_start_addr     = AW'(32'h123);
    rd_start_addr     = AW'(32'h456);
    wr_data           = 32'hCAFE_F00D;
    mem_wr_rdy        = 1;
    mem_rd_data_valid = 1;
    mem_rd_data       = 32'h1234_5678;
    last_rd           = 0;
    pend_valid        = 0;
    pend_last         = 0;
    pend_err          = 0;
    pend_data         = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_wr_en", 64'(mem_wr_en), 64'(1));
    chk("reset_rd_en", 64'(mem_rd_en), 64'(1));
    chk("reset_grants", 64'({wr_grant, rd_grant}), 64'(0));
    chk("reset_wr_pulses", 64'({wr_data_ack, wr_done}), 64'(0));
    chk("reset_rd_pulses", 64'({rd_data_valid, rd_done, rd_err}), 64'(0));
    chk("reset_rd_data", 64'(rd_data), 64'(0));
    chk("reset_wr_addr", 64'(mem_wr_addr), 64'(0));
    chk("reset_rd_addr", 64'(mem_rd_addr), 64'(0));
    chk("reset_wr_data_pass", 64'(mem_wr_data), 64'(32'hCAFE_F00D));
    @(negedge clk);
    reset = 1;

    // Arbitration table; bursts in between complete without stalls.
    for (int k = 0; k < 10; k++) begin
      do_idle(tbl[k].w, tbl[k].r, AW'(32'h100), AW'(32'h100), tbl[k].exp_w, tbl[k].exp_r);
      if (tbl[k].exp_w)      run_write(AW'(32'h100), -1, 0, 0, -1);
      else if (tbl[k].exp_r) run_read(AW'(32'h100), -1, 0);
    end

    // Write burst with a five-cycle ready stall at beat 7.
    do_idle(1, 0, AW'(32'h300), '0, 1, 0);
    run_write(AW'(32'h300), 7, 5, 0, -1);

    // Read burst wrapping through the top of the address space.
    do_idle(0, 1, '0, AW'(32'h1FFF_FFFE), 0, 1);
    run_read(AW'(32'h1FFF_FFFE), -1, 0);

    // Read beats 0..3 returned, then withheld until timeout.
    do_idle(0, 1, '0, AW'(32'h300), 0, 1);
    run_read(AW'(32'h300), 4, 0);

    // Reset during write beat 7, then a tie must go to read.
    do_idle(1, 0, AW'(32'h400), '0, 1, 0);
    run_write(AW'(32'h400), -1, 0, 0, 7);
    do_idle(1, 1, AW'(32'h500), AW'(32'h100), 0, 1);
    run_read(AW'(32'h100), -1, 0);

    for (int k = 0; k < 40; k++) begin
      w  = 1'($urandom);
      r  = 1'($urandom);
      wa = pick_addr();
      ra = pick_addr();
      er = r && (!w || !last_rd);
      ew = w && (!r || last_rd);
      do_idle(w, r, wa, ra, ew, er);
      if (ew)      run_write(wa, -1, 0, 1, -1);
      else if (er) run_read(ra, ($urandom_range(0, 5) == 0) ? $urandom_range(0, BL - 1) : -1, 1);
    end

    do_idle(0, 0, '0, '0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
